imem_responder: RTL

//  Instruction-memory responder: the memory side of the fetch interface. Accepts a byte

---
 rtl/imem_if.sv | 21 ++
 rtl/imem_responder.sv | 108 ++++++++++
 2 files changed

// File: rtl/imem_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory (slave).
// Request and response channels are independent valid/ready handshakes.
interface imem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] instr_out;
    logic        err;

    modport master (
        output req_valid, addr_in, resp_ready,
        input  req_ready, resp_valid, instr_out, err
    );

    modport slave (
        input  req_valid, addr_in, resp_ready,
        output req_ready, resp_valid, instr_out, err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency word lookup behind a valid/ready fetch bus,
// with a preload write port and a redirect flush.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    imem_if.slave                          bus,
    input  logic                           flush,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic        resp_valid_reg;
    logic [31:0] instr_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] lookup_addr;
    logic        lookup_bad;

    assign bus.req_ready  = reset & ~flush &
                            ((state_reg == IDLE) | ((state_reg == RESP) & bus.resp_ready));
    assign bus.resp_valid = resp_valid_reg;
    assign bus.instr_out  = instr_reg;
    assign bus.err        = err_reg;

    assign accept = bus.req_valid & bus.req_ready;

    // With LATENCY==1 the lookup happens on the accept edge itself, straight from addr_in.
    assign enter_resp  = ((state_reg == WAIT) && (cnt_reg == 4'd1)) ||
                         (accept && (LATENCY == 1));
    assign lookup_addr = (state_reg == WAIT) ? addr_reg : bus.addr_in;
    assign lookup_bad  = (lookup_addr[1:0] != 2'b00) ||
                         ({2'b00, lookup_addr[31:2]} >= 32'(DEPTH_WORDS));

    // Preload port; the lookup below reads the pre-write word on a same-edge collision.
    always_ff @(posedge clk) begin
        if (reset && ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            addr_reg       <= 32'd0;
            resp_valid_reg <= 1'b0;
            instr_reg      <= 32'd0;
            err_reg        <= 1'b0;
        end else if (flush) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_reg <= bus.addr_in;
                        cnt_reg  <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg      <= WAIT;
                            resp_valid_reg <= 1'b0;
                        end
                    end else if (state_reg == RESP && bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                if (lookup_bad) begin
                    instr_reg <= 32'h0000_0000;
                    err_reg   <= 1'b1;
                end else begin
                    instr_reg <= mem[lookup_addr[2 +: AW]];
                    err_reg   <= 1'b0;
                end
            end
        end
    end
endmodule
